// File: rtl/led_shift_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : led_shift_sched_if
// Description : Bus between two transfer requesters and the LED shift
//               scheduler. It carries the request/data/ack/done handshake for
//               both requesters, the serial LED shifter pins and the status
//               outputs.
//               master : drives en, req0/req1, data0/data1; observes the rest
//               slave  : the scheduler side
// Revision    : 1.0 - initial release
// ============================================================================
interface led_shift_sched_if;
    logic        en;
    logic        req0;
    logic        req1;
    logic [31:0] data0;
    logic [31:0] data1;
    logic        ack0;
    logic        ack1;
    logic        done0;
    logic        done1;
    logic        owner;
    logic        busy;
    logic        led_clk;
    logic        led_sout;
    logic        led_clrn;
    logic        led_pen;
    logic [31:0] shown_data;

    modport master (
        output en, req0, req1, data0, data1,
        input  ack0, ack1, done0, done1, owner, busy,
        input  led_clk, led_sout, led_clrn, led_pen, shown_data
    );

    modport slave (
        input  en, req0, req1, data0, data1,
        output ack0, ack1, done0, done1, owner, busy,
        output led_clk, led_sout, led_clrn, led_pen, shown_data
    );
endinterface
`default_nettype wire

// File: rtl/led_shift_sched.sv
`default_nettype none
// ============================================================================
// Module      : led_shift_sched
// Description : Round-robin scheduler for two requesters (CPU GPIO path on
//               index 0, display refresh path on index 1) sharing one serial
//               LED shift-register chain. A granted 32-bit word is shifted
//               out MSB first with DIV-cycle half periods on led_clk, then
//               latched with a DIV-cycle led_pen pulse.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous reset, active low
//               bus  - led_shift_sched_if.slave (handshake, LED pins, status)
// Parameters  : DIV  - led_clk half period in clk cycles (1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module led_shift_sched #(
    parameter int DIV = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    led_shift_sched_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_LATCH    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [7:0] c_div_last = 8'(DIV - 1);

    state_t      r_state;
    logic [7:0]  r_div_cnt;
    logic [4:0]  r_bit_cnt;
    logic [31:0] r_shreg;
    logic [31:0] r_word;
    logic [31:0] r_shown_data;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_done0;
    logic        r_done1;
    logic        r_owner;
    logic        r_last_grant;
    logic        r_busy;
    logic        r_led_clk;
    logic        r_led_sout;
    logic        r_led_clrn;
    logic        r_led_pen;

    logic        w_grant;
    logic [31:0] w_grant_data;
    logic        w_div_end;

    // With both requesters pending, the one not served last time wins.
    always_comb begin
        w_grant      = (bus.req0 && bus.req1) ? ~r_last_grant : bus.req1;
        w_grant_data = w_grant ? bus.data1 : bus.data0;
        w_div_end    = (r_div_cnt == c_div_last);
    end

    // Every output is registered; each transition also sets the output values
    // belonging to the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_word       <= '0;
            r_shown_data <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;   // requester 0 wins the first contention
            r_busy       <= 1'b0;
            r_led_clk    <= 1'b0;
            r_led_sout   <= 1'b0;
            r_led_clrn   <= 1'b0;
            r_led_pen    <= 1'b0;
        end else begin
            r_led_clrn <= 1'b1;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_div_cnt <= '0;
                    if (bus.en && (bus.req0 || bus.req1)) begin
                        r_state      <= S_LOAD;
                        r_busy       <= 1'b1;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_ack0       <= ~w_grant;
                        r_ack1       <= w_grant;
                        r_shreg      <= w_grant_data;
                        // r_word keeps the unshifted copy for shown_data
                        r_word       <= w_grant_data;
                    end
                end

                S_LOAD: begin
                    r_state    <= S_SHIFT_LO;
                    r_div_cnt  <= '0;
                    r_led_clk  <= 1'b0;
                    r_led_sout <= r_shreg[31];
                end

                S_SHIFT_LO: begin
                    if (w_div_end) begin
                        r_state   <= S_SHIFT_HI;
                        r_div_cnt <= '0;
                        r_led_clk <= 1'b1;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end

                S_SHIFT_HI: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        r_led_clk <= 1'b0;
                        r_shreg   <= {r_shreg[30:0], 1'b0};
                        // 5-bit count wraps 31->0 exactly when entering LATCH
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd31) begin
                            r_state    <= S_LATCH;
                            r_led_pen  <= 1'b1;
                            r_led_sout <= 1'b0;
                        end else begin
                            r_state    <= S_SHIFT_LO;
                            // next MSB, i.e. bit 30 of the pre-shift value
                            r_led_sout <= r_shreg[30];
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end

                S_LATCH: begin
                    if (w_div_end) begin
                        r_state      <= S_DONE;
                        r_div_cnt    <= '0;
                        r_led_pen    <= 1'b0;
                        r_done0      <= ~r_owner;
                        r_done1      <= r_owner;
                        r_shown_data <= r_word;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end

                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_div_cnt <= '0;
                    r_busy    <= 1'b0;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_div_cnt  <= '0;
                    r_busy     <= 1'b0;
                    r_led_clk  <= 1'b0;
                    r_led_sout <= 1'b0;
                    r_led_pen  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack0       = r_ack0;
    assign bus.ack1       = r_ack1;
    assign bus.done0      = r_done0;
    assign bus.done1      = r_done1;
    assign bus.owner      = r_owner;
    assign bus.busy       = r_busy;
    assign bus.led_clk    = r_led_clk;
    assign bus.led_sout   = r_led_sout;
    assign bus.led_clrn   = r_led_clrn;
    assign bus.led_pen    = r_led_pen;
    assign bus.shown_data = r_shown_data;

endmodule
`default_nettype wire

// File: tb/tb_led_shift_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_shift_sched
// Description : Self-checking bench for led_shift_sched. Two instances are
//               used: DIV=2 for most scenarios and DIV=1 for the data-toggle
//               scenario. A frame-level reference model (round-robin owner,
//               expected word, fixed latency) supplies all expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_shift_sched;

    localparam int DIV_A = 2;
    localparam int DIV_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_shift_sched_if bus_a ();
    led_shift_sched_if bus_b ();

    led_shift_sched #(.DIV(DIV_A)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    led_shift_sched #(.DIV(DIV_B)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    // Observation mux: sel_b chooses which instance the frame observer watches
    bit sel_b = 1'b0;
    wire        m_ack0     = sel_b ? bus_b.ack0     : bus_a.ack0;
    wire        m_ack1     = sel_b ? bus_b.ack1     : bus_a.ack1;
    wire        m_done0    = sel_b ? bus_b.done0    : bus_a.done0;
    wire        m_done1    = sel_b ? bus_b.done1    : bus_a.done1;
    wire        m_owner    = sel_b ? bus_b.owner    : bus_a.owner;
    wire        m_led_clk  = sel_b ? bus_b.led_clk  : bus_a.led_clk;
    wire        m_led_sout = sel_b ? bus_b.led_sout : bus_a.led_sout;
    wire        m_led_pen  = sel_b ? bus_b.led_pen  : bus_a.led_pen;
    wire [31:0] m_shown    = sel_b ? bus_b.shown_data : bus_a.shown_data;

    int n_cmp  = 0;
    int n_fail = 0;
    int viol   = 0;   // ack/done pulses that overlap or appear mid-frame

    // Reference model state
    int          model_last = 1;
    bit          pend [2];
    logic [31:0] word [2];

    // Observer results
    bit          ob_to;
    int          ob_acyc, ob_aidx, ob_own, ob_dcyc, ob_didx;
    logic [31:0] ob_bits;
    int          ob_rises, ob_pen, ob_unstable;

    function automatic int exp_grant();
        if (pend[0] && pend[1]) return 1 - model_last;
        return pend[1] ? 1 : 0;
    endfunction

    task automatic drv_req(input int idx, input logic v);
        if (sel_b) begin
            if (idx == 0) bus_b.req0 = v; else bus_b.req1 = v;
        end else begin
            if (idx == 0) bus_a.req0 = v; else bus_a.req1 = v;
        end
    endtask

    task automatic drv_data(input int idx, input logic [31:0] v);
        if (sel_b) begin
            if (idx == 0) bus_b.data0 = v; else bus_b.data1 = v;
        end else begin
            if (idx == 0) bus_a.data0 = v; else bus_a.data1 = v;
        end
    endtask

    task automatic drv_en(input logic v);
        if (sel_b) bus_b.en = v; else bus_a.en = v;
    endtask

    task automatic raise(input int idx);
        word[idx] = $urandom;
        drv_data(idx, word[idx]);
        drv_req(idx, 1'b1);
        pend[idx] = 1'b1;
    endtask

    // Waits for an ack, records the serial stream up to done, and behaves as
    // the requester: drops the finished req on seeing done.
    task automatic observe_frame(input int drop_en_after, input bit toggle_data);
        int   n;
        logic prev_clk, prev_sout;
        ob_to = 1'b0; ob_acyc = 0; ob_aidx = 0; ob_own = 0; ob_dcyc = 0; ob_didx = 0;
        ob_bits = '0; ob_rises = 0; ob_pen = 0; ob_unstable = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(m_ack0 || m_ack1) && n < 300);
        if (!(m_ack0 || m_ack1)) begin ob_to = 1'b1; return; end
        if (m_ack0 && m_ack1) viol++;
        ob_acyc = cyc;
        ob_aidx = m_ack1 ? 1 : 0;
        ob_own  = m_owner ? 1 : 0;
        prev_clk  = m_led_clk;
        prev_sout = m_led_sout;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n == drop_en_after) drv_en(1'b0);
            if (toggle_data) drv_data(1, sel_b ? ~bus_b.data1 : ~bus_a.data1);
            if (m_ack0 || m_ack1) viol++;
            if (m_led_clk && !prev_clk) begin
                ob_rises++;
                ob_bits = {ob_bits[30:0], m_led_sout};
                if (m_led_sout !== prev_sout) ob_unstable++;
            end
            if (m_led_pen) ob_pen++;
            prev_clk  = m_led_clk;
            prev_sout = m_led_sout;
            if (m_done0 || m_done1) begin
                if (m_done0 && m_done1) viol++;
                ob_dcyc = cyc;
                ob_didx = m_done1 ? 1 : 0;
                drv_req(ob_didx, 1'b0);
                return;
            end
            if (n >= 1000) begin ob_to = 1'b1; return; end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if ({bus_a.led_clk, bus_a.led_sout, bus_a.led_pen, bus_a.led_clrn} !== 4'b0)
            begin n_fail++; $display("FAIL reset_led_pins: got %b want 0000", {bus_a.led_clk, bus_a.led_sout, bus_a.led_pen, bus_a.led_clrn}); end
        n_cmp++; if ({bus_a.ack0, bus_a.ack1, bus_a.done0, bus_a.done1, bus_a.busy} !== 5'b0)
            begin n_fail++; $display("FAIL reset_pulses: got %b want 00000", {bus_a.ack0, bus_a.ack1, bus_a.done0, bus_a.done1, bus_a.busy}); end
        n_cmp++; if (bus_a.owner !== 1'b0 || bus_a.shown_data !== 32'h0)
            begin n_fail++; $display("FAIL reset_owner_shown: got %b/%h want 0/0", bus_a.owner, bus_a.shown_data); end
        rst = 1'b1;
        n_cmp++; if (bus_a.led_clrn !== 1'b0)
            begin n_fail++; $display("FAIL clrn_before_edge: got %b want 0", bus_a.led_clrn); end
        @(negedge clk);
        n_cmp++; if (bus_a.led_clrn !== 1'b1 || bus_b.led_clrn !== 1'b1)
            begin n_fail++; $display("FAIL clrn_after_edge: got %b%b want 11", bus_a.led_clrn, bus_b.led_clrn); end
    endtask

    task automatic test_single;
        sel_b = 1'b0;
        word[0] = 32'hA5A5_0F0F;
        drv_data(0, word[0]);
        drv_req(0, 1'b1);
        pend[0] = 1'b1;
        observe_frame(-1, 1'b0);
        n_cmp++; if (ob_to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b want 0", ob_to); end
        n_cmp++; if (ob_aidx != 0 || ob_own != 0 || ob_didx != 0)
            begin n_fail++; $display("FAIL single_owner: got ack%0d own%0d done%0d want 0", ob_aidx, ob_own, ob_didx); end
        n_cmp++; if (ob_dcyc - ob_acyc != 1 + 65 * DIV_A)
            begin n_fail++; $display("FAIL single_latency: got %0d want %0d", ob_dcyc - ob_acyc, 1 + 65 * DIV_A); end
        n_cmp++; if (ob_bits !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL single_bits: got %h want a5a50f0f", ob_bits); end
        n_cmp++; if (ob_rises != 32 || ob_unstable != 0)
            begin n_fail++; $display("FAIL single_edges: got %0d rises %0d unstable want 32/0", ob_rises, ob_unstable); end
        n_cmp++; if (ob_pen != DIV_A) begin n_fail++; $display("FAIL single_pen: got %0d want %0d", ob_pen, DIV_A); end
        n_cmp++; if (m_shown !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL single_shown: got %h want a5a50f0f", m_shown); end
        pend[0] = 1'b0;
        model_last = 0;
        @(negedge clk);
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b want 0", bus_a.busy); end
    endtask

    task automatic test_contention;
        int exp;
        int prev_d;
        sel_b = 1'b0;
        @(negedge clk);
        raise(0);
        raise(1);
        prev_d = 0;
        for (int k = 0; k < 4; k++) begin
            exp = exp_grant();
            observe_frame(-1, 1'b0);
            n_cmp++; if (ob_to !== 1'b0 || ob_aidx != exp || ob_didx != exp)
                begin n_fail++; $display("FAIL rr_order[%0d]: got to%0b ack%0d done%0d want %0d", k, ob_to, ob_aidx, ob_didx, exp); end
            n_cmp++; if (ob_bits !== word[exp] || m_shown !== word[exp])
                begin n_fail++; $display("FAIL rr_data[%0d]: got %h/%h want %h", k, ob_bits, m_shown, word[exp]); end
            if (k > 0) begin
                n_cmp++; if (ob_acyc - prev_d != 2)
                    begin n_fail++; $display("FAIL rr_gap[%0d]: got %0d want 2", k, ob_acyc - prev_d); end
            end
            prev_d = ob_dcyc;
            model_last = exp;
            pend[exp] = 1'b0;
            @(negedge clk);
            if (k < 2) raise(exp);
        end
    endtask

    task automatic test_enable;
        int acks;
        int t_en;
        sel_b = 1'b0;
        drv_en(1'b0);
        raise(1);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.ack0 || bus_a.ack1) acks++;
        end
        n_cmp++; if (acks != 0) begin n_fail++; $display("FAIL en_block: got %0d acks want 0", acks); end
        drv_en(1'b1);
        t_en = cyc;
        observe_frame(10, 1'b0);
        n_cmp++; if (ob_to !== 1'b0 || ob_aidx != 1 || ob_acyc - t_en != 1)
            begin n_fail++; $display("FAIL en_grant: got to%0b ack%0d after %0d want ack1 after 1", ob_to, ob_aidx, ob_acyc - t_en); end
        n_cmp++; if (ob_didx != 1 || ob_bits !== word[1] || ob_dcyc - ob_acyc != 1 + 65 * DIV_A)
            begin n_fail++; $display("FAIL en_midframe: got done%0d %h lat %0d want 1 %h %0d", ob_didx, ob_bits, ob_dcyc - ob_acyc, word[1], 1 + 65 * DIV_A); end
        pend[1] = 1'b0;
        model_last = 1;
        drv_en(1'b1);
        @(negedge clk);
    endtask

    task automatic test_div1;
        logic [31:0] w;
        sel_b = 1'b1;
        w = $urandom;
        drv_data(1, w);
        drv_req(1, 1'b1);
        observe_frame(-1, 1'b1);
        n_cmp++; if (ob_to !== 1'b0 || ob_didx != 1 || ob_dcyc - ob_acyc != 66)
            begin n_fail++; $display("FAIL div1_latency: got to%0b done%0d lat %0d want 66", ob_to, ob_didx, ob_dcyc - ob_acyc); end
        n_cmp++; if (ob_bits !== w || m_shown !== w)
            begin n_fail++; $display("FAIL div1_data: got %h/%h want %h", ob_bits, m_shown, w); end
        n_cmp++; if (ob_rises != 32 || ob_pen != DIV_B || ob_unstable != 0)
            begin n_fail++; $display("FAIL div1_shape: got %0d/%0d/%0d want 32/%0d/0", ob_rises, ob_pen, ob_unstable, DIV_B); end
        @(negedge clk);
        sel_b = 1'b0;
    endtask

    task automatic test_reset_midframe;
        int   n;
        int   rises;
        int   dones;
        logic prev;
        sel_b = 1'b0;
        @(negedge clk);
        raise(1);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_a.ack1 && n < 50);
        n_cmp++; if (bus_a.ack1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack: got %b want 1", bus_a.ack1); end
        rises = 0;
        prev  = bus_a.led_clk;
        while (rises < 17 && n < 600) begin
            @(negedge clk);
            n++;
            if (bus_a.led_clk && !prev) rises++;
            prev = bus_a.led_clk;
        end
        n_cmp++; if (bus_a.busy !== 1'b1 || bus_a.owner !== 1'b1)
            begin n_fail++; $display("FAIL rstmid_pre: got busy%b owner%b want 1/1", bus_a.busy, bus_a.owner); end
        rst = 1'b0;
        drv_req(1, 1'b0);
        pend[1] = 1'b0;
        #1;
        n_cmp++; if ({bus_a.led_clk, bus_a.led_sout, bus_a.led_pen, bus_a.led_clrn, bus_a.busy, bus_a.owner} !== 6'b0)
            begin n_fail++; $display("FAIL rstmid_pins: got %b want 000000", {bus_a.led_clk, bus_a.led_sout, bus_a.led_pen, bus_a.led_clrn, bus_a.busy, bus_a.owner}); end
        n_cmp++; if (bus_a.shown_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_shown: got %h want 0", bus_a.shown_data); end
        model_last = 1;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus_a.done0 || bus_a.done1 || bus_a.ack0 || bus_a.ack1) dones++;
        end
        rst = 1'b1;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_cmp++; if (bus_a.led_clrn !== 1'b1) begin n_fail++; $display("FAIL rstmid_clrn: got %b want 1", bus_a.led_clrn); end
            end
            if (bus_a.done0 || bus_a.done1 || bus_a.ack0 || bus_a.ack1) dones++;
        end
        n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dones); end
        // both request after reset: requester 0 wins first, then 1
        raise(0);
        raise(1);
        for (int k = 0; k < 2; k++) begin
            int exp;
            exp = exp_grant();
            observe_frame(-1, 1'b0);
            n_cmp++; if (ob_to !== 1'b0 || ob_aidx != exp || ob_bits !== word[exp] || m_shown !== word[exp])
                begin n_fail++; $display("FAIL rstmid_serve[%0d]: got to%0b ack%0d %h want %0d %h", k, ob_to, ob_aidx, ob_bits, exp, word[exp]); end
            model_last = exp;
            pend[exp]  = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int exp;
        int acks;
        sel_b = 1'b0;
        for (int it = 0; it < 8; it++) begin
            @(negedge clk);
            for (int idx = 0; idx < 2; idx++)
                if (!pend[idx] && $urandom_range(0, 1) == 1) raise(idx);
            if (!pend[0] && !pend[1]) raise(int'($urandom_range(0, 1)));
            exp = exp_grant();
            observe_frame(-1, 1'b0);
            n_cmp++; if (ob_to !== 1'b0 || ob_aidx != exp || ob_didx != exp || ob_own != exp)
                begin n_fail++; $display("FAIL rand_grant[%0d]: got to%0b ack%0d done%0d own%0d want %0d", it, ob_to, ob_aidx, ob_didx, ob_own, exp); end
            n_cmp++; if (ob_bits !== word[exp] || m_shown !== word[exp] || ob_dcyc - ob_acyc != 1 + 65 * DIV_A)
                begin n_fail++; $display("FAIL rand_frame[%0d]: got %h/%h lat %0d want %h lat %0d", it, ob_bits, m_shown, ob_dcyc - ob_acyc, word[exp], 1 + 65 * DIV_A); end
            model_last = exp;
            pend[exp]  = 1'b0;
        end
        // a request withdrawn before it is sampled must never be served
        @(negedge clk);
        drv_req(0, 1'b0);
        drv_req(1, 1'b0);
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_a.ack0 || bus_a.ack1 || bus_a.done0 || bus_a.done1) acks++;
        end
        n_cmp++; if (acks != 0) begin n_fail++; $display("FAIL dropped_req: got %0d pulses want 0", acks); end
    endtask

    initial begin
        bus_a.en = 1'b1; bus_a.req0 = 1'b0; bus_a.req1 = 1'b0; bus_a.data0 = '0; bus_a.data1 = '0;
        bus_b.en = 1'b1; bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; bus_b.data0 = '0; bus_b.data1 = '0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        word[0] = '0;
        word[1] = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_enable();
        test_div1();
        test_reset_midframe();
        test_random();
        n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d stray pulses want 0", viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
